// File: rtl/sound_tone_player.sv
// sound_tone_player: turns a sound-effect code into a looping 4-note square wave on a 1-bit audio pin.
module sound_tone_player #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned NOTE_FRAMES = 4,
  parameter int unsigned HP_W        = 20
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       frame_start,
  input  logic       enable_sound,
  input  logic [3:0] sound,
  output logic       audio_out,
  output logic       busy,
  output logic [1:0] note_idx
);
  localparam int unsigned FC_W = $clog2(NOTE_FRAMES + 1);

  function automatic logic [HP_W-1:0] hp(input int unsigned f);
    return (f == 0) ? '0 : HP_W'(CLK_HZ / (2 * f));
  endfunction

  localparam logic [HP_W-1:0] HP_CR0 = hp(200);
  localparam logic [HP_W-1:0] HP_CR1 = hp(150);
  localparam logic [HP_W-1:0] HP_CR2 = hp(100);
  localparam logic [HP_W-1:0] HP_BO0 = hp(523);
  localparam logic [HP_W-1:0] HP_BO1 = hp(659);
  localparam logic [HP_W-1:0] HP_BO2 = hp(784);
  localparam logic [HP_W-1:0] HP_BO3 = hp(1047);
  localparam logic [HP_W-1:0] HP_ED  = hp(300);

  if (64'(CLK_HZ) / 200 >= (64'd1 << HP_W)) begin : g_hp_check
    $error("sound_tone_player: HP_W too narrow for the lowest note");
  end
  if (NOTE_FRAMES < 1) begin : g_nf_check
    $error("sound_tone_player: NOTE_FRAMES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_code, w_code_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [HP_W-1:0] r_hp, r_tone, w_rom;
  logic [FC_W-1:0] r_frames;
  logic            r_audio;
  logic            w_valid, w_note_end;

  assign w_valid    = enable_sound && (sound == 4'b0100 || sound == 4'b0111 || sound == 4'b1100);
  assign w_note_end = (r_state == PLAY) && frame_start && (r_frames == FC_W'(NOTE_FRAMES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_idx_nxt   = r_idx;
    if (r_state == IDLE) begin
      if (w_valid) begin
        w_state_nxt = LOAD;
        w_code_nxt  = sound;
        w_idx_nxt   = 2'd0;
      end
    end else if (!w_valid) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = 2'd0;
    end else if (sound != r_code) begin
      w_state_nxt = LOAD;
      w_code_nxt  = sound;
      w_idx_nxt   = 2'd0;
    end else if (r_state == LOAD) begin
      w_state_nxt = PLAY;
    end else if (w_note_end) begin
      // Reaching here means the same effect is still requested, so note 3 wraps to 0 and loops.
      w_state_nxt = LOAD;
      w_idx_nxt   = r_idx + 2'd1;
    end
  end

  always_comb begin
    w_rom = '0;
    case ({r_code, r_idx})
      6'b0100_00: w_rom = HP_CR0;
      6'b0100_01: w_rom = HP_CR1;
      6'b0100_10: w_rom = HP_CR2;
      6'b0111_00: w_rom = HP_BO0;
      6'b0111_01: w_rom = HP_BO1;
      6'b0111_10: w_rom = HP_BO2;
      6'b0111_11: w_rom = HP_BO3;
      6'b1100_00: w_rom = HP_ED;
      6'b1100_10: w_rom = HP_ED;
      default:    w_rom = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_code   <= '0;
      r_idx    <= '0;
      r_hp     <= '0;
      r_tone   <= '0;
      r_frames <= '0;
      r_audio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == LOAD) r_hp <= w_rom;
      r_frames <= (r_state != PLAY) ? '0 : frame_start ? r_frames + FC_W'(1) : r_frames;
      // Silence whenever not staying in PLAY, and on rest notes.
      if (r_state != PLAY || w_state_nxt != PLAY || r_hp == '0) begin
        r_tone  <= '0;
        r_audio <= 1'b0;
      end else if (r_tone == r_hp - HP_W'(1)) begin
        r_tone  <= '0;
        r_audio <= ~r_audio;
      end else begin
        r_tone <= r_tone + HP_W'(1);
      end
    end
  end

  assign audio_out = r_audio;
  assign busy      = (r_state != IDLE);
  assign note_idx  = r_idx;
endmodule

// File: tb/tb_sound_tone_player.sv
// tb_sound_tone_player: vector table, directed note-timing sequences and random traffic against a reference model.
module tb_sound_tone_player;
  localparam int CLK_HZ = 100_000;
  localparam int NF     = 2;
  localparam int FP     = 1000;
  localparam int LIM    = 5000;

  logic       clk = 1'b0, resetN = 1'b1, frame_start = 1'b0, enable_sound = 1'b0;
  logic [3:0] sound = 4'b0000;
  logic       audio_out, busy;
  logic [1:0] note_idx;

  always #5 clk = ~clk;

  sound_tone_player #(.CLK_HZ(CLK_HZ), .NOTE_FRAMES(NF), .HP_W(20)) dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start), .enable_sound(enable_sound),
    .sound(sound), .audio_out(audio_out), .busy(busy), .note_idx(note_idx)
  );

  int checks = 0, failures = 0;
  int m_mode = 0, m_idx = 0, m_t = 0, m_frames = 0, m_hp = 0, fphase = 0;
  logic [3:0] m_code = 4'b0000;

  typedef struct {
    logic       en;
    logic [3:0] snd;
    logic       fs;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[11];

  function automatic int freq(input logic [3:0] c, input int i);
    int t[4];
    case (c)
      4'b0100: t = '{200, 150, 100, 0};
      4'b0111: t = '{523, 659, 784, 1047};
      4'b1100: t = '{300, 0, 300, 0};
      default: t = '{0, 0, 0, 0};
    endcase
    return t[i];
  endfunction

  function automatic int hp_of(input logic [3:0] c, input int i);
    int f;
    f = freq(c, i);
    return (f == 0) ? 0 : CLK_HZ / (2 * f);
  endfunction

  function automatic bit valid(input logic en, input logic [3:0] s);
    return en && (s == 4'b0100 || s == 4'b0111 || s == 4'b1100);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_t = 0; m_frames = 0; m_hp = 0; m_code = 4'b0000;
  endtask

  task automatic model_step(input logic en, input logic [3:0] snd, input logic fs);
    if (m_mode == 0) begin
      if (valid(en, snd)) begin m_mode = 1; m_code = snd; m_idx = 0; end
    end else if (!valid(en, snd)) begin
      m_mode = 0; m_idx = 0;
    end else if (snd != m_code) begin
      m_mode = 1; m_code = snd; m_idx = 0;
    end else if (m_mode == 1) begin
      m_mode = 2; m_t = 0; m_frames = 0; m_hp = hp_of(m_code, m_idx);
    end else begin
      if (fs) m_frames++;
      if (m_frames == NF) begin m_idx = (m_idx + 1) % 4; m_mode = 1; end
      else m_t++;
    end
  endtask

  task automatic cycle(input logic en, input logic [3:0] snd, input logic fs);
    logic ea;
    enable_sound = en; sound = snd; frame_start = fs;
    @(posedge clk);
    model_step(en, snd, fs);
    @(negedge clk);
    ea = (m_mode == 2 && m_hp > 0) ? 1'((m_t / m_hp) % 2) : 1'b0;
    check("model busy/idx/audio", {busy, note_idx, audio_out}, {1'(m_mode != 0), 2'(m_idx), ea});
  endtask

  task automatic tick(input logic en, input logic [3:0] snd);
    logic fs;
    fs = (fphase == FP - 1);
    fphase = (fphase + 1) % FP;
    cycle(en, snd, fs);
  endtask

  task automatic wait_toggle(input logic en, input logic [3:0] snd, output int n);
    logic a0;
    a0 = audio_out;
    n = 0;
    do begin tick(en, snd); n++; end while (audio_out === a0 && n < LIM);
  endtask

  task automatic wait_idx(input logic en, input logic [3:0] snd, input logic [1:0] target);
    int n;
    n = 0;
    while (note_idx !== target && n < LIM) begin tick(en, snd); n++; end
    check("reach note_idx", note_idx, target);
  endtask

  task automatic note_hp(input logic [3:0] snd, input int hp, input string name);
    int n;
    wait_toggle(1'b1, snd, n);
    check({name, " first toggle"}, n, hp + 1);
    wait_toggle(1'b1, snd, n);
    check({name, " half-period"}, n, hp);
  endtask

  task automatic rest_note(input logic [3:0] snd, input logic [1:0] idx, input string name);
    int ones, n;
    ones = 0; n = 0;
    while (note_idx === idx && n < LIM) begin tick(1'b1, snd); ones += int'(audio_out); n++; end
    check(name, ones, 0);
  endtask

  initial begin
    int bonus_hp[4];
    int n;
    bonus_hp = '{95, 75, 63, 47};
    tbl = '{
      '{1'b1, 4'b0011, 1'b0, 4'b0000},
      '{1'b1, 4'b0000, 1'b0, 4'b0000},
      '{1'b0, 4'b0111, 1'b0, 4'b0000},
      '{1'b1, 4'b0111, 1'b0, 4'b1000},
      '{1'b1, 4'b0111, 1'b0, 4'b1000},
      '{1'b1, 4'b0111, 1'b1, 4'b1000},
      '{1'b1, 4'b0011, 1'b0, 4'b0000},
      '{1'b1, 4'b1100, 1'b0, 4'b1000},
      '{1'b1, 4'b0100, 1'b1, 4'b1000},
      '{1'b1, 4'b0100, 1'b0, 4'b1000},
      '{1'b0, 4'b0100, 1'b0, 4'b0000}
    };
    #2 resetN = 1'b0;
    #1 check("reset outputs", {busy, note_idx, audio_out}, 4'b0000);
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].en, tbl[i].snd, tbl[i].fs);
      check($sformatf("vec%0d", i), {busy, note_idx, audio_out}, tbl[i].exp);
    end
    fphase = 0;

    tick(1'b1, 4'b0111);
    note_hp(4'b0111, bonus_hp[0], "bonus n0");
    for (int k = 1; k < 4; k++) begin
      wait_idx(1'b1, 4'b0111, 2'(k));
      note_hp(4'b0111, bonus_hp[k], $sformatf("bonus n%0d", k));
    end
    wait_idx(1'b1, 4'b0111, 2'd0);
    note_hp(4'b0111, bonus_hp[0], "bonus loop n0");

    wait_toggle(1'b1, 4'b0111, n);
    resetN = 1'b0;
    #1 check("reset mid-play", {busy, note_idx, audio_out}, 4'b0000);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    tick(1'b1, 4'b0111);
    check("restart busy", busy, 1'b1);
    tick(1'b0, 4'b0000);

    tick(1'b1, 4'b0100);
    note_hp(4'b0100, 250, "crash n0");
    wait_idx(1'b1, 4'b0100, 2'd1);
    note_hp(4'b0100, 333, "crash n1");
    wait_toggle(1'b1, 4'b0100, n);
    check("crash audio high", audio_out, 1'b1);
    tick(1'b0, 4'b0100);
    check("crash drop", {busy, note_idx, audio_out}, 4'b0000);

    tick(1'b1, 4'b1100);
    note_hp(4'b1100, 166, "edge n0");
    wait_idx(1'b1, 4'b1100, 2'd1);
    rest_note(4'b1100, 2'd1, "edge n1 silent");
    note_hp(4'b1100, 166, "edge n2");
    wait_idx(1'b1, 4'b1100, 2'd3);
    rest_note(4'b1100, 2'd3, "edge n3 silent");
    check("edge loop idx", note_idx, 2'd0);
    tick(1'b0, 4'b0000);

    cycle(1'b1, 4'b0111, 1'b0);
    cycle(1'b1, 4'b0111, 1'b0);
    cycle(1'b1, 4'b0111, 1'b1);
    repeat (5) cycle(1'b1, 4'b0111, 1'b0);
    cycle(1'b1, 4'b0100, 1'b1);
    check("switch busy/idx", {busy, note_idx}, 3'b100);
    note_hp(4'b0100, 250, "switch crash n0");

    tick(1'b0, 4'b0000);
    repeat (50) tick(1'b1, 4'b0011);
    check("invalid code idle", {busy, audio_out}, 2'b00);
    tick(1'b1, 4'b0100);
    repeat (10) tick(1'b1, 4'b0100);
    tick(1'b1, 4'b0011);
    check("invalid during play", busy, 1'b0);

    for (int s = 0; s < 12; s++) begin
      logic en;
      logic [3:0] snd;
      int len;
      en = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 4))
        0: snd = 4'b0100;
        1: snd = 4'b0111;
        2: snd = 4'b1100;
        default: snd = 4'($urandom);
      endcase
      len = $urandom_range(1, 1500);
      repeat (len) tick(en, snd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
